// File: rtl/alu_issue_stage_if.sv
// Bundle between decode, the memory/writeback forwarding sources, the alu
// and the execute issue stage. The slave modport is the stage's view.
interface alu_issue_stage_if #(
    parameter int OP_W = 11,
    parameter int XLEN = 32
);
    logic            flush;
    logic            ds_to_es_valid;
    logic            es_allowin;
    logic [OP_W-1:0] ds_alu_op;
    logic [XLEN-1:0] ds_pc;
    logic [XLEN-1:0] ds_imm;
    logic [XLEN-1:0] ds_rs1_val;
    logic [XLEN-1:0] ds_rs2_val;
    logic [4:0]      ds_rs1;
    logic [4:0]      ds_rs2;
    logic [4:0]      ds_rd;
    logic            ds_src1_is_pc;
    logic            ds_src2_is_imm;
    logic            ds_src2_is_4;
    logic            ds_gr_we;
    logic            ms_valid;
    logic            ms_gr_we;
    logic            ms_is_load;
    logic [4:0]      ms_rd;
    logic [XLEN-1:0] ms_result;
    logic            ws_valid;
    logic            ws_gr_we;
    logic [4:0]      ws_rd;
    logic [XLEN-1:0] ws_result;
    logic [XLEN-1:0] alu_src1;
    logic [XLEN-1:0] alu_src2;
    logic [OP_W-1:0] alu_sel;
    logic [XLEN-1:0] alu_result;
    logic            ms_allowin;
    logic            es_to_ms_valid;
    logic [4:0]      es_rd;
    logic            es_gr_we;
    logic [XLEN-1:0] es_result;

    modport slave (
        input  flush, ds_to_es_valid, ds_alu_op, ds_pc, ds_imm, ds_rs1_val, ds_rs2_val,
               ds_rs1, ds_rs2, ds_rd, ds_src1_is_pc, ds_src2_is_imm, ds_src2_is_4, ds_gr_we,
               ms_valid, ms_gr_we, ms_is_load, ms_rd, ms_result,
               ws_valid, ws_gr_we, ws_rd, ws_result, alu_result, ms_allowin,
        output es_allowin, alu_src1, alu_src2, alu_sel, es_to_ms_valid, es_rd, es_gr_we, es_result
    );

    modport master (
        output flush, ds_to_es_valid, ds_alu_op, ds_pc, ds_imm, ds_rs1_val, ds_rs2_val,
               ds_rs1, ds_rs2, ds_rd, ds_src1_is_pc, ds_src2_is_imm, ds_src2_is_4, ds_gr_we,
               ms_valid, ms_gr_we, ms_is_load, ms_rd, ms_result,
               ws_valid, ws_gr_we, ws_rd, ws_result, alu_result, ms_allowin,
        input  es_allowin, alu_src1, alu_src2, alu_sel, es_to_ms_valid, es_rd, es_gr_we, es_result
    );
endinterface

// File: rtl/alu_issue_stage.sv
// Execute issue stage: holds one decoded instruction, forwards operands from
// mem/wb, stalls on load-use and hands the alu result to the memory stage.
module alu_issue_stage #(
    parameter int OP_W = 11,
    parameter int XLEN = 32
) (
    input logic               clk,
    input logic               reset,
    alu_issue_stage_if.slave  bus
);
    logic            es_valid;
    logic [OP_W-1:0] op_r;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] imm_r;
    logic [XLEN-1:0] rs1_val_r;
    logic [XLEN-1:0] rs2_val_r;
    logic [4:0]      rs1_r;
    logic [4:0]      rs2_r;
    logic [4:0]      rd_r;
    logic            src1_is_pc_r;
    logic            src2_is_imm_r;
    logic            src2_is_4_r;
    logic            gr_we_r;

    logic [1:0][4:0]      src_rs;
    logic [1:0][XLEN-1:0] src_rf;
    logic [1:0][XLEN-1:0] fwd_val;
    logic [1:0]           fwd_load;
    logic                 load_use;
    logic                 es_ready_go;
    logic                 allowin;

    assign src_rs[0] = rs1_r;
    assign src_rs[1] = rs2_r;
    assign src_rf[0] = rs1_val_r;
    assign src_rf[1] = rs2_val_r;

    // Newest producer wins; x0 never forwards and never stalls.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            fwd_val[i]  = src_rf[i];
            fwd_load[i] = 1'b0;
            if (src_rs[i] == 5'd0) begin
                fwd_val[i] = '0;
            end else if (bus.ms_valid && bus.ms_gr_we && (bus.ms_rd == src_rs[i])) begin
                fwd_val[i]  = bus.ms_result;
                fwd_load[i] = bus.ms_is_load;
            end else if (bus.ws_valid && bus.ws_gr_we && (bus.ws_rd == src_rs[i])) begin
                fwd_val[i] = bus.ws_result;
            end
        end
    end

    assign load_use    = (!src1_is_pc_r && fwd_load[0])
                       || (!src2_is_imm_r && !src2_is_4_r && fwd_load[1]);
    assign es_ready_go = !(es_valid && load_use);
    assign allowin     = !es_valid || (es_ready_go && bus.ms_allowin);

    assign bus.es_allowin     = allowin;
    assign bus.es_to_ms_valid = es_valid && es_ready_go && !bus.flush;
    assign bus.alu_src1       = src1_is_pc_r ? pc_r : fwd_val[0];
    assign bus.alu_src2       = src2_is_imm_r ? imm_r
                              : src2_is_4_r   ? XLEN'(4)
                              : fwd_val[1];
    assign bus.alu_sel        = es_valid ? op_r : '0;
    assign bus.es_result      = bus.alu_result;
    assign bus.es_rd          = rd_r;
    assign bus.es_gr_we       = es_valid && gr_we_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            es_valid      <= 1'b0;
            op_r          <= '0;
            pc_r          <= '0;
            imm_r         <= '0;
            rs1_val_r     <= '0;
            rs2_val_r     <= '0;
            rs1_r         <= '0;
            rs2_r         <= '0;
            rd_r          <= '0;
            src1_is_pc_r  <= 1'b0;
            src2_is_imm_r <= 1'b0;
            src2_is_4_r   <= 1'b0;
            gr_we_r       <= 1'b0;
        end else if (bus.flush) begin
            es_valid <= 1'b0;
        end else if (allowin) begin
            es_valid <= bus.ds_to_es_valid;
            if (bus.ds_to_es_valid) begin
                op_r          <= bus.ds_alu_op;
                pc_r          <= bus.ds_pc;
                imm_r         <= bus.ds_imm;
                rs1_val_r     <= bus.ds_rs1_val;
                rs2_val_r     <= bus.ds_rs2_val;
                rs1_r         <= bus.ds_rs1;
                rs2_r         <= bus.ds_rs2;
                rd_r          <= bus.ds_rd;
                src1_is_pc_r  <= bus.ds_src1_is_pc;
                src2_is_imm_r <= bus.ds_src2_is_imm;
                src2_is_4_r   <= bus.ds_src2_is_4;
                gr_we_r       <= bus.ds_gr_we;
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed vector table, hand sequences for
// backpressure/flush/reset, then random traffic against a reference model.
module tb_alu_issue_stage;
    logic clk;
    logic reset;

    alu_issue_stage_if #(.OP_W(11), .XLEN(32)) bus ();

    alu_issue_stage #(.OP_W(11), .XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [10:0] s);
        return a ^ {b[15:0], b[31:16]} ^ {21'd0, s};
    endfunction

    assign bus.alu_result = alu_f(bus.alu_src1, bus.alu_src2, bus.alu_sel);

    typedef struct {
        logic        flush;
        logic        ds_valid;
        logic [10:0] op;
        logic [31:0] pc, imm, rs1_val, rs2_val;
        logic [4:0]  rs1, rs2, rd;
        logic        src1_is_pc, src2_is_imm, src2_is_4, gr_we;
        logic        ms_valid, ms_gr_we, ms_is_load;
        logic [4:0]  ms_rd;
        logic [31:0] ms_result;
        logic        ws_valid, ws_gr_we;
        logic [4:0]  ws_rd;
        logic [31:0] ws_result;
        logic        ms_allowin;
    } in_t;

    typedef struct {
        logic        ds_valid;
        logic [10:0] op;
        logic [4:0]  rs1, rs2;
        logic [31:0] rs1_val, rs2_val;
        logic        ms_valid, ms_is_load;
        logic [4:0]  ms_rd;
        logic [31:0] ms_result;
        logic        ws_valid;
        logic [4:0]  ws_rd;
        logic [31:0] ws_result;
        logic [31:0] e_src1, e_src2;
        logic        e_tmv, e_allowin;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // reference model state: the one held instruction
    logic        m_valid;
    in_t         m_ins;
    logic        e_allowin, e_tmv, e_gr_we;
    logic [31:0] e_src1, e_src2, e_result;
    logic [10:0] e_sel;
    logic [4:0]  e_rd;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic in_t idle();
        in_t c;
        c.flush = 0; c.ds_valid = 0; c.op = '0; c.pc = '0; c.imm = '0;
        c.rs1_val = '0; c.rs2_val = '0; c.rs1 = '0; c.rs2 = '0; c.rd = '0;
        c.src1_is_pc = 0; c.src2_is_imm = 0; c.src2_is_4 = 0; c.gr_we = 0;
        c.ms_valid = 0; c.ms_gr_we = 0; c.ms_is_load = 0; c.ms_rd = '0; c.ms_result = '0;
        c.ws_valid = 0; c.ws_gr_we = 0; c.ws_rd = '0; c.ws_result = '0;
        c.ms_allowin = 1;
        return c;
    endfunction

    function automatic in_t from_vec(input vec_t v, input int idx);
        in_t c;
        c = idle();
        c.ds_valid = v.ds_valid; c.op = v.op; c.rs1 = v.rs1; c.rs2 = v.rs2;
        c.rs1_val = v.rs1_val; c.rs2_val = v.rs2_val; c.rd = 5'(idx); c.gr_we = 1;
        c.ms_valid = v.ms_valid; c.ms_gr_we = 1; c.ms_is_load = v.ms_is_load;
        c.ms_rd = v.ms_rd; c.ms_result = v.ms_result;
        c.ws_valid = v.ws_valid; c.ws_gr_we = 1; c.ws_rd = v.ws_rd; c.ws_result = v.ws_result;
        return c;
    endfunction

    function automatic in_t rnd_in();
        in_t c;
        c = idle();
        c.flush       = ($urandom_range(0, 15) == 0);
        c.ds_valid    = ($urandom_range(0, 3) != 0);
        c.op          = 11'd1 << $urandom_range(0, 10);
        c.pc          = $urandom();
        c.imm         = $urandom();
        c.rs1_val     = $urandom();
        c.rs2_val     = $urandom();
        c.rs1         = 5'($urandom_range(0, 3));
        c.rs2         = 5'($urandom_range(0, 3));
        c.rd          = 5'($urandom_range(0, 31));
        c.src1_is_pc  = ($urandom_range(0, 3) == 0);
        c.src2_is_imm = ($urandom_range(0, 3) == 0);
        c.src2_is_4   = ($urandom_range(0, 3) == 0);
        c.gr_we       = 1'($urandom_range(0, 1));
        c.ms_valid    = 1'($urandom_range(0, 1));
        c.ms_gr_we    = ($urandom_range(0, 3) != 0);
        c.ms_is_load  = 1'($urandom_range(0, 1));
        c.ms_rd       = 5'($urandom_range(0, 3));
        c.ms_result   = $urandom();
        c.ws_valid    = 1'($urandom_range(0, 1));
        c.ws_gr_we    = ($urandom_range(0, 3) != 0);
        c.ws_rd       = 5'($urandom_range(0, 3));
        c.ws_result   = $urandom();
        c.ms_allowin  = ($urandom_range(0, 3) != 0);
        return c;
    endfunction

    task automatic drive(input in_t c);
        bus.flush = c.flush; bus.ds_to_es_valid = c.ds_valid; bus.ds_alu_op = c.op;
        bus.ds_pc = c.pc; bus.ds_imm = c.imm; bus.ds_rs1_val = c.rs1_val; bus.ds_rs2_val = c.rs2_val;
        bus.ds_rs1 = c.rs1; bus.ds_rs2 = c.rs2; bus.ds_rd = c.rd;
        bus.ds_src1_is_pc = c.src1_is_pc; bus.ds_src2_is_imm = c.src2_is_imm;
        bus.ds_src2_is_4 = c.src2_is_4; bus.ds_gr_we = c.gr_we;
        bus.ms_valid = c.ms_valid; bus.ms_gr_we = c.ms_gr_we; bus.ms_is_load = c.ms_is_load;
        bus.ms_rd = c.ms_rd; bus.ms_result = c.ms_result;
        bus.ws_valid = c.ws_valid; bus.ws_gr_we = c.ws_gr_we; bus.ws_rd = c.ws_rd;
        bus.ws_result = c.ws_result; bus.ms_allowin = c.ms_allowin;
    endtask

    // {load_hit, value} of a source register: newest writer in flight, else regfile
    function automatic logic [32:0] operand(input logic [4:0] r, input logic [31:0] rf, input in_t c);
        if (r == 5'd0) return 33'd0;
        if (c.ms_valid && c.ms_gr_we && c.ms_rd == r) return {c.ms_is_load, c.ms_result};
        if (c.ws_valid && c.ws_gr_we && c.ws_rd == r) return {1'b0, c.ws_result};
        return {1'b0, rf};
    endfunction

    task automatic predict(input in_t c);
        logic [32:0] o1, o2;
        logic        hz;
        o1 = operand(m_ins.rs1, m_ins.rs1_val, c);
        o2 = operand(m_ins.rs2, m_ins.rs2_val, c);
        hz = m_valid && ((!m_ins.src1_is_pc && o1[32])
                      || (!m_ins.src2_is_imm && !m_ins.src2_is_4 && o2[32]));
        e_allowin = !m_valid || (!hz && c.ms_allowin);
        e_tmv     = m_valid && !hz && !c.flush;
        e_src1    = m_ins.src1_is_pc ? m_ins.pc : o1[31:0];
        e_src2    = m_ins.src2_is_imm ? m_ins.imm : (m_ins.src2_is_4 ? 32'd4 : o2[31:0]);
        e_sel     = m_valid ? m_ins.op : 11'd0;
        e_gr_we   = m_valid && m_ins.gr_we;
        e_rd      = m_ins.rd;
        e_result  = alu_f(e_src1, e_src2, e_sel);
    endtask

    task automatic setup(input in_t c);
        @(negedge clk);
        drive(c);
        #1;
        predict(c);
        check("es_allowin", 64'(bus.es_allowin), 64'(e_allowin));
        check("es_to_ms_valid", 64'(bus.es_to_ms_valid), 64'(e_tmv));
        check("alu_src1", 64'(bus.alu_src1), 64'(e_src1));
        check("alu_src2", 64'(bus.alu_src2), 64'(e_src2));
        check("alu_sel", 64'(bus.alu_sel), 64'(e_sel));
        check("es_gr_we", 64'(bus.es_gr_we), 64'(e_gr_we));
        check("es_rd", 64'(bus.es_rd), 64'(e_rd));
        check("es_result", 64'(bus.es_result), 64'(e_result));
    endtask

    task automatic advance(input in_t c);
        @(posedge clk);
        if (c.flush) m_valid = 1'b0;
        else if (e_allowin) begin
            m_valid = c.ds_valid;
            if (c.ds_valid) m_ins = c;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_allowin"}, 64'(bus.es_allowin), 64'd1);
        check({tag, "_tmv"}, 64'(bus.es_to_ms_valid), 64'd0);
        check({tag, "_sel"}, 64'(bus.alu_sel), 64'd0);
        check({tag, "_src1"}, 64'(bus.alu_src1), 64'd0);
        check({tag, "_src2"}, 64'(bus.alu_src2), 64'd0);
    endtask

    vec_t vecs[11];
    in_t  c;

    initial begin
        vecs[0]  = '{1, 11'h001, 5'd1, 5'd2, 32'h80000000, 32'h10, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0,
                     32'h0, 32'h0, 0, 1};
        vecs[1]  = '{0, 11'h0, 5'd0, 5'd0, 32'h0, 32'h0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0,
                     32'h80000000, 32'h10, 1, 1};
        vecs[2]  = '{1, 11'h004, 5'd5, 5'd0, 32'h99, 32'h0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0,
                     32'h80000000, 32'h10, 0, 1};
        vecs[3]  = '{0, 11'h0, 5'd0, 5'd0, 32'h0, 32'h0, 1, 0, 5'd5, 32'h11, 1, 5'd5, 32'h22,
                     32'h11, 32'h0, 1, 1};
        vecs[4]  = '{0, 11'h0, 5'd0, 5'd0, 32'h0, 32'h0, 0, 0, 5'd0, 32'h0, 1, 5'd5, 32'h22,
                     32'h22, 32'h0, 0, 1};
        vecs[5]  = '{1, 11'h008, 5'd0, 5'd7, 32'h33, 32'h44, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0,
                     32'h99, 32'h0, 0, 1};
        vecs[6]  = '{0, 11'h0, 5'd0, 5'd0, 32'h0, 32'h0, 1, 0, 5'd0, 32'h11, 1, 5'd0, 32'h22,
                     32'h0, 32'h44, 1, 1};
        vecs[7]  = '{1, 11'h010, 5'd0, 5'd7, 32'h66, 32'h55, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0,
                     32'h0, 32'h44, 0, 1};
        vecs[8]  = '{1, 11'h020, 5'd3, 5'd0, 32'h3, 32'h9, 1, 1, 5'd7, 32'h77, 0, 5'd0, 32'h0,
                     32'h0, 32'h77, 0, 0};
        vecs[9]  = '{1, 11'h020, 5'd3, 5'd0, 32'h3, 32'h9, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0,
                     32'h0, 32'h55, 1, 1};
        vecs[10] = '{0, 11'h0, 5'd0, 5'd0, 32'h0, 32'h0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0,
                     32'h3, 32'h0, 1, 1};

        reset = 1'b1;
        m_valid = 1'b0;
        m_ins = idle();
        drive(idle());
        @(negedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            c = from_vec(vecs[i], i);
            setup(c);
            check($sformatf("vec%0d_src1", i), 64'(bus.alu_src1), 64'(vecs[i].e_src1));
            check($sformatf("vec%0d_src2", i), 64'(bus.alu_src2), 64'(vecs[i].e_src2));
            check($sformatf("vec%0d_tmv", i), 64'(bus.es_to_ms_valid), 64'(vecs[i].e_tmv));
            check($sformatf("vec%0d_allowin", i), 64'(bus.es_allowin), 64'(vecs[i].e_allowin));
            if (i == 1) check("vec1_sel", 64'(bus.alu_sel), 64'h001);
            advance(c);
        end

        // backpressure: A held for two cycles while B is offered
        c = idle(); c.ds_valid = 1; c.op = 11'h040; c.rs1 = 9; c.rs1_val = 32'hA;
        c.rs2 = 10; c.rs2_val = 32'hB; c.rd = 4; c.gr_we = 1;
        setup(c); advance(c);
        c = idle(); c.ds_valid = 1; c.op = 11'h080; c.rs1 = 1; c.rs1_val = 32'h1; c.ms_allowin = 0;
        for (int k = 0; k < 2; k++) begin
            setup(c);
            check("bp_allowin", 64'(bus.es_allowin), 64'd0);
            check("bp_sel", 64'(bus.alu_sel), 64'h040);
            check("bp_src1", 64'(bus.alu_src1), 64'hA);
            check("bp_src2", 64'(bus.alu_src2), 64'hB);
            advance(c);
        end
        c.ms_allowin = 1;
        setup(c);
        check("bp_release_sel", 64'(bus.alu_sel), 64'h040);
        advance(c);

        // flush beats a simultaneous capture
        c = idle(); c.flush = 1; c.ds_valid = 1; c.op = 11'h100; c.rs1 = 2;
        setup(c);
        check("flush_hold_sel", 64'(bus.alu_sel), 64'h080);
        check("flush_tmv", 64'(bus.es_to_ms_valid), 64'd0);
        advance(c);
        c = idle();
        setup(c);
        check("post_flush_sel", 64'(bus.alu_sel), 64'd0);
        check("post_flush_tmv", 64'(bus.es_to_ms_valid), 64'd0);
        advance(c);

        // reset asserted in the middle of a load-use stall
        c = idle(); c.ds_valid = 1; c.op = 11'h200; c.rs1 = 6; c.rs1_val = 32'h6; c.rd = 6;
        setup(c); advance(c);
        c = idle(); c.ms_valid = 1; c.ms_gr_we = 1; c.ms_is_load = 1; c.ms_rd = 6; c.ms_result = 32'h66;
        setup(c);
        check("stall_allowin", 64'(bus.es_allowin), 64'd0);
        #2 reset = 1'b1;
        #1;
        m_valid = 1'b0;
        m_ins = idle();
        check_zero("midreset");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        c = idle(); c.ds_valid = 1; c.op = 11'h400; c.rs1 = 2; c.rs1_val = 32'h1234;
        setup(c); advance(c);
        c = idle();
        setup(c);
        check("post_reset_sel", 64'(bus.alu_sel), 64'h400);
        check("post_reset_src1", 64'(bus.alu_src1), 64'h1234);
        advance(c);

        for (int n = 0; n < 400; n++) begin
            c = rnd_in();
            setup(c);
            advance(c);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 Parameter: OP_W, 11, width of the one-hot ALU opcode; must match the alu sel port.
REQ-002 Parameter: XLEN, 32, datapath width.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 flush  input  1  synchronous kill of the held instruction (branch/exception redirect).
REQ-006 ds_to_es_valid  input  1  decode offers an instruction this cycle.
REQ-007 es_allowin  output  1  stage can accept a new instruction this cycle.
REQ-008 ds_alu_op  input  OP_W  one-hot ALU operation from decode.
REQ-009 ds_pc / ds_imm / ds_rs1_val / ds_rs2_val  input  XLEN each  PC, sign-extended immediate and regfile read data.
REQ-010 ds_rs1 / ds_rs2 / ds_rd  input  5 each  register indices.
REQ-011 ds_src1_is_pc / ds_src2_is_imm / ds_src2_is_4 / ds_gr_we  input  1 each  operand-select and writeback flags.
REQ-012 ms_valid, ms_gr_we, ms_is_load  input  1 each  memory-stage forwarding status.
REQ-013 ms_rd  input  5; ms_result  input  XLEN  memory-stage destination and value.
REQ-014 ws_valid, ws_gr_we  input  1 each; ws_rd  input  5; ws_result  input  XLEN  writeback-stage forwarding.
REQ-015 alu_src1 / alu_src2  output  XLEN  operands driven to alu.
REQ-016 alu_sel  output  OP_W  opcode driven to alu.
REQ-017 alu_result  input  XLEN  combinational result returned by alu.
REQ-018 ms_allowin  input  1  downstream can accept.
REQ-019 es_to_ms_valid  output  1; es_rd  output  5; es_gr_we  output  1; es_result  output  XLEN  handoff to memory stage.

Function
REQ-020 Stage SHALL hold one instruction in registers: es_valid plus captured copies of every ds_* field.
REQ-021 es_ready_go SHALL be 0 iff es_valid and a load-use hazard exists (REQ-026), else 1.
REQ-022 es_allowin SHALL equal !es_valid || (es_ready_go && ms_allowin).
REQ-023 es_to_ms_valid SHALL equal es_valid && es_ready_go && !flush.
REQ-024 On a rising edge with flush=1, es_valid SHALL become 0 regardless of ds_to_es_valid; flush overrides capture.
REQ-025 Else if es_allowin=1, es_valid SHALL load ds_to_es_valid and, when ds_to_es_valid=1, all fields SHALL be captured; if es_allowin=0 all registers SHALL hold.
REQ-026 Forwarding per source operand rsN (N=1,2), combinational, priority: rsN==0 -> 0; ms_valid&&ms_gr_we&&ms_rd==rsN -> ms_result (load-use hazard if ms_is_load); ws_valid&&ws_gr_we&&ws_rd==rsN -> ws_result; else captured regfile value.
REQ-027 Hazard counts only for operands actually used: rs1 if !src1_is_pc, rs2 if !src2_is_imm && !src2_is_4.
REQ-028 alu_src1 SHALL be captured pc if src1_is_pc, else forwarded rs1.
REQ-029 alu_src2 SHALL be imm if src2_is_imm, else 32'd4 if src2_is_4, else forwarded rs2; src2_is_imm wins if both set.
REQ-030 alu_sel SHALL be captured alu_op when es_valid, else all zeros; opcode passes unmodified (no re-encoding).
REQ-031 es_result SHALL equal alu_result; es_rd, es_gr_we SHALL be captured values; es_gr_we gated to 0 when !es_valid.
REQ-032 Zero-latency through stage: instruction captured at edge N drives alu and es_to_ms_valid in cycle N+1 absent stall.
REQ-033 Stall released the cycle ms no longer matches; operands re-evaluated each cycle, no stale latching.

Reset
REQ-034 reset=1 SHALL asynchronously clear es_valid and all captured fields to 0; hence es_allowin=1, es_to_ms_valid=0, alu_sel=0, alu_src1=0, alu_src2=0 during and after reset.
REQ-035 Reset mid-stall SHALL discard the held instruction; first edge after release may capture a new one.

Verification
REQ-036 Capture: ds add, rs1_val=0x80000000, rs2_val=0x10, ms/ws idle -> next cycle alu_src1=0x80000000, alu_src2=0x10, alu_sel=ds_alu_op, es_to_ms_valid=1.
REQ-037 Forward priority: rs1=5, ms_rd=5 result 0x11, ws_rd=5 result 0x22 -> alu_src1=0x11; drop ms -> 0x22; rs1=0 with matches -> 0.
REQ-038 Load-use: ms_is_load, ms_rd=rs2=7 -> es_to_ms_valid=0, es_allowin=0 for the cycle, ds held off; ms clears -> proceed.
REQ-039 Backpressure: ms_allowin=0 two cycles -> fields stable, es_allowin=0; new ds ignored until released.
REQ-040 Flush with simultaneous ds_to_es_valid=1 -> es_valid=0 next cycle, alu_sel=0; reset asserted mid-stall -> all outputs zero immediately.
